golomb_rice_serializer: RTL and testbench

GOLOMB_RICE_SERIALIZER -- requirements
Module: golomb_rice_serializer

---
 rtl/golomb_rice_serializer.sv | 127 ++++++++++++
 tb/tb_golomb_rice_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/golomb_rice_serializer.sv
// Golomb-Rice codeword serializer: one code bit per bit_valid/bit_ready transfer, MSB first.
// Build option GOLOMB_LIMIT_EN caps codewords at LIMIT bits using an escape code.
`ifndef MODRESIDUAL_LENGTH
`define MODRESIDUAL_LENGTH 8
`endif

module golomb_rice_serializer #(
    parameter int MERR_W = `MODRESIDUAL_LENGTH,
    parameter int K_W    = 4,
    parameter int QBPP   = 8,
    parameter int LIMIT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MERR_W-1:0] merr_in,
    input  logic [K_W-1:0]    k_in,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              code_last
);
    // state  | meaning
    // IDLE   | waiting for a symbol, in_ready high
    // PREFIX | emitting unary zeros, preCnt still to go
    // STOP   | emitting the terminating 1
    // SUFFIX | emitting sufCnt remaining suffix bits, MSB first
    typedef enum logic [1:0] {IDLE, PREFIX, STOP, SUFFIX} stateT;

    localparam int DW   = (MERR_W > QBPP) ? MERR_W : QBPP;
    localparam int PMAX = (LIMIT > (1 << MERR_W)) ? LIMIT : (1 << MERR_W);
    localparam int PCW  = $clog2(PMAX + 1);
    localparam int SCW  = $clog2(DW + 1);
`ifdef GOLOMB_LIMIT_EN
    localparam int ESC  = LIMIT - QBPP - 1;
`endif

    stateT          state, stateNext;
    logic [PCW-1:0] preCnt, preCntNext;
    logic [SCW-1:0] sufCnt, sufCntNext;
    logic [DW-1:0]  sufData, sufDataNext;
    logic [SCW-1:0] kEff;
    logic [SCW-1:0] sufIdx;
    logic [MERR_W-1:0] qVal;
    logic [DW-1:0]  sufShift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            preCnt  <= '0;
            sufCnt  <= '0;
            sufData <= '0;
        end else begin
            state   <= stateNext;
            preCnt  <= preCntNext;
            sufCnt  <= sufCntNext;
            sufData <= sufDataNext;
        end
    end

    always_comb begin
        stateNext   = state;
        preCntNext  = preCnt;
        sufCntNext  = sufCnt;
        sufDataNext = sufData;
        in_ready    = 1'b0;
        bit_valid   = 1'b0;
        bit_out     = 1'b0;
        code_last   = 1'b0;
        kEff        = (32'(k_in) > QBPP) ? SCW'(QBPP) : SCW'(k_in);
        qVal        = merr_in >> kEff;
        sufIdx      = sufCnt - SCW'(1);
        sufShift    = sufData >> sufIdx;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    preCntNext  = PCW'(qVal);
                    sufCntNext  = kEff;
                    sufDataNext = DW'(merr_in);
`ifdef GOLOMB_LIMIT_EN
                    // quotient too long: fixed-length prefix then raw (merr-1)
                    if (int'(qVal) >= ESC) begin
                        preCntNext  = PCW'(ESC);
                        sufCntNext  = SCW'(QBPP);
                        sufDataNext = DW'(merr_in) - DW'(1);
                    end
`endif
                    stateNext = (preCntNext == '0) ? STOP : PREFIX;
                end
            end
            PREFIX: begin
                bit_valid = 1'b1;
                if (bit_ready) begin
                    preCntNext = preCnt - PCW'(1);
                    if (preCnt == PCW'(1)) stateNext = STOP;
                end
            end
            STOP: begin
                bit_valid = 1'b1;
                bit_out   = 1'b1;
                code_last = (sufCnt == '0);
                if (bit_ready) stateNext = (sufCnt == '0) ? IDLE : SUFFIX;
            end
            SUFFIX: begin
                bit_valid = 1'b1;
                bit_out   = sufShift[0];
                code_last = (sufCnt == SCW'(1));
                if (bit_ready) begin
                    sufCntNext = sufCnt - SCW'(1);
                    if (sufCnt == SCW'(1)) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // outputs read as idle for the whole reset window
        if (rst) begin
            in_ready  = 1'b0;
            bit_valid = 1'b0;
            bit_out   = 1'b0;
            code_last = 1'b0;
        end
    end
endmodule

// File: tb/tb_golomb_rice_serializer.sv
// Bench for golomb_rice_serializer: vector table, hand-written corner sequences, random symbols vs. model.
`timescale 1ns/1ps
module tb_golomb_rice_serializer;
    localparam int QBPP  = 8;
    localparam int LIMIT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] merr_in;
    logic [3:0] k_in;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       code_last;

    int nCompared = 0;
    int nMismatch = 0;
    bit expQ[$];

    typedef struct {
        int          merr;
        int          k;
        int          stall;
        int          expLen;
        logic [63:0] expBits;
    } vecT;
    vecT vecs[$];

    golomb_rice_serializer #(.MERR_W(8), .K_W(4), .QBPP(QBPP), .LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .merr_in(merr_in), .k_in(k_in), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .code_last(code_last)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void addVec(int merr, int k, int stall, int len, logic [63:0] bits);
        vecT v;
        v.merr = merr; v.k = k; v.stall = stall; v.expLen = len; v.expBits = bits;
        vecs.push_back(v);
    endfunction

    // Reference code built straight from the coding rules.
    function automatic void modelCode(int merr, int k);
        int kk = (k > QBPP) ? QBPP : k;
        int q  = merr >> kk;
        expQ.delete();
`ifdef GOLOMB_LIMIT_EN
        if (q >= LIMIT - QBPP - 1) begin
            for (int i = 0; i < LIMIT - QBPP - 1; i++) expQ.push_back(1'b0);
            expQ.push_back(1'b1);
            for (int i = QBPP - 1; i >= 0; i--) expQ.push_back(bit'(((merr - 1) >> i) & 1));
            return;
        end
`endif
        for (int i = 0; i < q; i++) expQ.push_back(1'b0);
        expQ.push_back(1'b1);
        for (int i = kk - 1; i >= 0; i--) expQ.push_back(bit'((merr >> i) & 1));
    endfunction

    task automatic runSymbol(input int merr, input int k, input int stallMode);
        int guard = 0;
        int idx = 0;
        int cyc = 0;
        int last;
        bit rdy;
        bit bv;
        last = expQ.size() - 1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before", int'(in_ready), 1);
        merr_in   = 8'(merr);
        k_in      = 4'(k);
        in_valid  = 1'b1;
        bit_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        merr_in  = 8'($urandom);
        k_in     = 4'($urandom);
        while (idx <= last && cyc < 4000) begin
            bv = bit_valid;
            check("bit_valid", int'(bit_valid), 1);
            check("in_ready_busy", int'(in_ready), 0);
            check("bit_out", int'(bit_out), int'(expQ[idx]));
            check("code_last", int'(code_last), int'(idx == last));
            case (stallMode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bit_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy && bv) idx++;
        end
        bit_ready = 1'b0;
        check("bits_transferred", idx, last + 1);
        check("in_ready_after", int'(in_ready), 1);
        check("bit_valid_idle", int'(bit_valid), 0);
    endtask

    initial begin
        addVec(5, 1, 0, 4, 64'h3);
        addVec(0, 0, 0, 1, 64'h1);
        addVec(6, 2, 1, 4, 64'h6);
        addVec(3, 12, 0, 9, 64'h103);
        addVec(13, 3, 0, 5, 64'hD);
        addVec(255, 8, 1, 9, 64'h1FF);
        addVec(255, 7, 0, 9, 64'hFF);
        addVec(22, 0, 0, 23, 64'h1);
        addVec(9, 15, 0, 9, 64'h109);
`ifdef GOLOMB_LIMIT_EN
        addVec(23, 0, 0, 32, 64'h116);
        addVec(200, 0, 1, 32, 64'h1C7);
`else
        addVec(23, 0, 0, 24, 64'h1);
`endif

        rst       = 1'b1;
        in_valid  = 1'b1;
        bit_ready = 1'b1;
        merr_in   = 8'd7;
        k_in      = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_code_last", int'(code_last), 0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        bit_ready = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_bit_valid", int'(bit_valid), 0);

        foreach (vecs[i]) begin
            expQ.delete();
            for (int b = vecs[i].expLen - 1; b >= 0; b--) expQ.push_back(vecs[i].expBits[b]);
            runSymbol(vecs[i].merr, vecs[i].k, vecs[i].stall);
        end

`ifndef GOLOMB_LIMIT_EN
        expQ.delete();
        for (int i = 0; i < 200; i++) expQ.push_back(1'b0);
        expQ.push_back(1'b1);
        runSymbol(200, 0, 0);
`endif

        // reset in the middle of a long prefix abandons the codeword
        in_valid = 1'b1;
        merr_in  = 8'd40;
        k_in     = 4'd0;
        @(negedge clk);
        in_valid  = 1'b0;
        bit_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_prefix_valid", int'(bit_valid), 1);
        check("mid_prefix_bit", int'(bit_out), 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_bit_valid", int'(bit_valid), 0);
        check("abort_in_ready", int'(in_ready), 0);
        rst       = 1'b0;
        bit_ready = 1'b0;
        @(negedge clk);
        check("abort_release_in_ready", int'(in_ready), 1);
        check("abort_release_bit_valid", int'(bit_valid), 0);
        expQ.delete();
        expQ.push_back(1'b0); expQ.push_back(1'b0); expQ.push_back(1'b1); expQ.push_back(1'b1);
        runSymbol(5, 1, 0);

        for (int n = 0; n < 40; n++) begin
            int m;
            int kr;
            m  = int'($urandom_range(0, 255));
            kr = int'($urandom_range(0, 15));
            modelCode(m, kr);
            runSymbol(m, kr, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
